// File: rtl/uc_pkg.sv
// Shared constants and types for the uc_seq sequencing control unit:
// opcode encodings, instruction-class masks and the FSM state type.
package uc_pkg;

    localparam int OPCODE_W = 6;
    localparam int IMM_W    = 10;
    localparam int ALU_W    = 3;

    // Any opcode with bit 5 clear is an ALU operation; bits [4:2] select the op.
    localparam logic [OPCODE_W-1:0] ALU_CLASS_MASK  = 6'b100000;
    localparam logic [OPCODE_W-1:0] ALU_CLASS_VAL   = 6'b000000;
    localparam logic [OPCODE_W-1:0] LOADI_MASK      = 6'b111100;

    localparam logic [OPCODE_W-1:0] OP_LOADI = 6'b100000;
    localparam logic [OPCODE_W-1:0] OP_JMP   = 6'b100100;
    localparam logic [OPCODE_W-1:0] OP_JZ    = 6'b100101;
    localparam logic [OPCODE_W-1:0] OP_JNZ   = 6'b100110;
    localparam logic [OPCODE_W-1:0] OP_NOP   = 6'b100111;
    localparam logic [OPCODE_W-1:0] OP_WAIT  = 6'b101000;
    localparam logic [OPCODE_W-1:0] OP_HALT  = 6'b111111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    function automatic logic is_alu_op(input logic [OPCODE_W-1:0] op);
        return (op & ALU_CLASS_MASK) == ALU_CLASS_VAL;
    endfunction

    function automatic logic is_loadi_op(input logic [OPCODE_W-1:0] op);
        return (op & LOADI_MASK) == OP_LOADI;
    endfunction

endpackage

// File: rtl/uc_seq_if.sv
// Control-unit boundary: instruction fields and flags from the datapath in,
// datapath control word and status out.
interface uc_seq_if;
    import uc_pkg::*;

    logic [OPCODE_W-1:0] opcode;
    logic [IMM_W-1:0]    imm;
    logic                z;
    logic                start;

    logic                s_inc;
    logic                s_inm;
    logic                we3;
    logic                wez;
    logic [ALU_W-1:0]    op_alu;
    logic                pc_en;
    logic                halted;
    logic                err;

    modport master (
        output opcode, imm, z, start,
        input  s_inc, s_inm, we3, wez, op_alu, pc_en, halted, err
    );

    modport slave (
        input  opcode, imm, z, start,
        output s_inc, s_inm, we3, wez, op_alu, pc_en, halted, err
    );

endinterface

// File: rtl/uc_decode.sv
// Purely combinational opcode + zero-flag decode into the raw control word.
// State-dependent gating (pc_en, idle defaults) is applied by uc_seq.
module uc_decode
    import uc_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                z,
    output logic                s_inc,
    output logic                s_inm,
    output logic                we3,
    output logic                wez,
    output logic [ALU_W-1:0]    op_alu,
    output logic                is_wait,
    output logic                is_halt,
    output logic                illegal
);

    always_comb begin
        s_inc   = 1'b1;
        s_inm   = 1'b0;
        we3     = 1'b0;
        wez     = 1'b0;
        op_alu  = '0;
        is_wait = 1'b0;
        is_halt = 1'b0;
        illegal = 1'b0;

        if (is_alu_op(opcode)) begin
            op_alu = opcode[4:2];
            we3    = 1'b1;
            wez    = 1'b1;
        end else if (is_loadi_op(opcode)) begin
            s_inm = 1'b1;
            we3   = 1'b1;
        end else begin
            case (opcode)
                OP_JMP:  s_inc   = 1'b0;
                OP_JZ:   s_inc   = ~z;
                OP_JNZ:  s_inc   = z;
                OP_NOP:  s_inc   = 1'b1;
                OP_WAIT: is_wait = 1'b1;
                OP_HALT: is_halt = 1'b1;
                // Unknown opcodes fall through as NOP but are flagged.
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/uc_seq.sv
// Sequencing control unit: IDLE/RUN/WAIT/HALT FSM wrapped around uc_decode,
// producing a zero-latency control word plus the PC enable.
module uc_seq
    import uc_pkg::*;
#(
    parameter int WAIT_W     = 8,
    parameter bit AUTO_START = 1'b0
) (
    input  logic      clk,
    input  logic      reset,
    uc_seq_if.slave   bus
);

    localparam state_t RESET_STATE = AUTO_START ? ST_RUN : ST_IDLE;

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] cnt_reg, cnt_next;
    logic              err_reg, err_next;

    logic              dec_s_inc, dec_s_inm, dec_we3, dec_wez;
    logic [ALU_W-1:0]  dec_op_alu;
    logic              dec_is_wait, dec_is_halt, dec_illegal;

    logic [WAIT_W-1:0] wait_n;

    logic              s_inc, s_inm, we3, wez, pc_en;
    logic [ALU_W-1:0]  op_alu;

    assign wait_n = bus.imm[WAIT_W-1:0];

    uc_decode u_decode (
        .opcode  (bus.opcode),
        .z       (bus.z),
        .s_inc   (dec_s_inc),
        .s_inm   (dec_s_inm),
        .we3     (dec_we3),
        .wez     (dec_wez),
        .op_alu  (dec_op_alu),
        .is_wait (dec_is_wait),
        .is_halt (dec_is_halt),
        .illegal (dec_illegal)
    );

    always_comb begin
        s_inc      = 1'b1;
        s_inm      = 1'b0;
        we3        = 1'b0;
        wez        = 1'b0;
        op_alu     = '0;
        pc_en      = 1'b0;
        state_next = state_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) state_next = ST_RUN;
            end
            ST_RUN: begin
                s_inc  = dec_s_inc;
                s_inm  = dec_s_inm;
                we3    = dec_we3;
                wez    = dec_wez;
                op_alu = dec_op_alu;
                pc_en  = 1'b1;
                if (dec_illegal) err_next = 1'b1;
                if (dec_is_halt) begin
                    pc_en      = 1'b0;
                    state_next = ST_HALT;
                end else if (dec_is_wait && (wait_n != '0)) begin
                    pc_en      = 1'b0;
                    cnt_next   = wait_n;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The last counted cycle also retires the WAIT, giving n+1 total.
                if (cnt_reg <= WAIT_W'(1)) begin
                    pc_en      = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_RUN;
                end else begin
                    cnt_next = cnt_reg - WAIT_W'(1);
                end
            end
            ST_HALT: begin
                if (bus.start) begin
                    pc_en      = 1'b1;
                    state_next = ST_RUN;
                end
            end
            default: state_next = RESET_STATE;
        endcase

        if (reset) begin
            s_inc  = 1'b1;
            s_inm  = 1'b0;
            we3    = 1'b0;
            wez    = 1'b0;
            op_alu = '0;
            pc_en  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RESET_STATE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    assign bus.s_inc  = s_inc;
    assign bus.s_inm  = s_inm;
    assign bus.we3    = we3;
    assign bus.wez    = wez;
    assign bus.op_alu = op_alu;
    assign bus.pc_en  = pc_en;
    assign bus.halted = (state_reg == ST_HALT);
    assign bus.err    = err_reg;

endmodule

// File: tb/tb_uc_seq.sv
// Directed bench for uc_seq: decode table in RUN plus hand-written sequences
// for start, WAIT, HALT, illegal opcode and mid-WAIT reset.
module tb_uc_seq;
    import uc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    uc_seq_if bus1();
    uc_seq_if bus2();

    uc_seq #(.WAIT_W(8), .AUTO_START(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    uc_seq #(.WAIT_W(8), .AUTO_START(1'b1)) dut_auto (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    // Control word: {pc_en, s_inc, s_inm, we3, wez, op_alu[2:0], halted, err}
    function automatic logic [9:0] cw(input logic pc, input logic si, input logic sm,
                                      input logic w3, input logic wz, input logic [2:0] alu,
                                      input logic h, input logic e);
        return {pc, si, sm, w3, wz, alu, h, e};
    endfunction

    function automatic logic [9:0] cw1();
        return {bus1.pc_en, bus1.s_inc, bus1.s_inm, bus1.we3, bus1.wez,
                bus1.op_alu, bus1.halted, bus1.err};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    typedef struct {
        string      nm;
        logic [5:0] opcode;
        logic [9:0] imm;
        logic       z;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[13];
    logic [9:0] w_idle, w_wait, w_run_nop;
    int   cnt;

    initial begin
        w_idle    = cw(0, 1, 0, 0, 0, 3'b000, 0, 0);
        w_wait    = w_idle;
        w_run_nop = cw(1, 1, 0, 0, 0, 3'b000, 0, 0);

        vecs[0]  = '{"alu001",    6'b000100, 10'h000, 1'b0, cw(1, 1, 0, 1, 1, 3'b001, 0, 0)};
        vecs[1]  = '{"alu111",    6'b011100, 10'h000, 1'b1, cw(1, 1, 0, 1, 1, 3'b111, 0, 0)};
        vecs[2]  = '{"alu000",    6'b000011, 10'h000, 1'b0, cw(1, 1, 0, 1, 1, 3'b000, 0, 0)};
        vecs[3]  = '{"alu010",    6'b001010, 10'h3ff, 1'b0, cw(1, 1, 0, 1, 1, 3'b010, 0, 0)};
        vecs[4]  = '{"loadi00",   6'b100000, 10'h055, 1'b0, cw(1, 1, 1, 1, 0, 3'b000, 0, 0)};
        vecs[5]  = '{"loadi11",   6'b100011, 10'h0aa, 1'b1, cw(1, 1, 1, 1, 0, 3'b000, 0, 0)};
        vecs[6]  = '{"jmp",       6'b100100, 10'h000, 1'b1, cw(1, 0, 0, 0, 0, 3'b000, 0, 0)};
        vecs[7]  = '{"jz_z1",     6'b100101, 10'h000, 1'b1, cw(1, 0, 0, 0, 0, 3'b000, 0, 0)};
        vecs[8]  = '{"jz_z0",     6'b100101, 10'h000, 1'b0, cw(1, 1, 0, 0, 0, 3'b000, 0, 0)};
        vecs[9]  = '{"jnz_z0",    6'b100110, 10'h000, 1'b0, cw(1, 0, 0, 0, 0, 3'b000, 0, 0)};
        vecs[10] = '{"jnz_z1",    6'b100110, 10'h000, 1'b1, cw(1, 1, 0, 0, 0, 3'b000, 0, 0)};
        vecs[11] = '{"wait0",     6'b101000, 10'h000, 1'b0, cw(1, 1, 0, 0, 0, 3'b000, 0, 0)};
        vecs[12] = '{"wait0_hi",  6'b101000, 10'h100, 1'b0, cw(1, 1, 0, 0, 0, 3'b000, 0, 0)};

        reset = 1'b1;
        bus1.opcode = 6'b000100; bus1.imm = '0; bus1.z = 1'b0; bus1.start = 1'b0;
        bus2.opcode = 6'b000100; bus2.imm = '0; bus2.z = 1'b0; bus2.start = 1'b0;

        // Reset held two cycles
        step();
        step();
        settle();
        chk("rst_cw", 16'(cw1()), 16'(w_idle));
        chk("rst_auto_pc_en", 16'(bus2.pc_en), 16'(1'b0));
        reset = 1'b0;
        settle();
        chk("auto_first_pc_en", 16'(bus2.pc_en), 16'(1'b1));
        chk("auto_first_we3", 16'(bus2.we3), 16'(1'b1));

        for (int i = 0; i < 5; i++) begin
            chk("idle_cw", 16'(cw1()), 16'(w_idle));
            chk("idle_state", 16'(dut.state_reg), 16'(ST_IDLE));
            step();
            settle();
        end

        // start pulse: still IDLE in the pulse cycle
        bus1.start = 1'b1;
        settle();
        chk("start_cycle_cw", 16'(cw1()), 16'(w_idle));
        step();
        bus1.start = 1'b0;

        foreach (vecs[i]) begin
            bus1.opcode = vecs[i].opcode;
            bus1.imm    = vecs[i].imm;
            bus1.z      = vecs[i].z;
            settle();
            chk(vecs[i].nm, 16'(cw1()), 16'(vecs[i].exp));
            step();
        end

        // WAIT 3: three stalled cycles, release on the fourth
        bus1.opcode = OP_WAIT; bus1.imm = 10'd3;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("wait3_stall", 16'(cw1()), 16'(w_wait));
            step();
        end
        settle();
        chk("wait3_release", 16'(cw1()), 16'(w_run_nop));
        step();
        bus1.opcode = OP_NOP;
        settle();
        chk("wait3_back_run", 16'(cw1()), 16'(w_run_nop));
        step();

        // WAIT at max count: 255 stalled cycles, no wrap
        bus1.opcode = OP_WAIT; bus1.imm = 10'h0ff;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            settle();
            if (bus1.pc_en === 1'b1) break;
            cnt++;
            step();
        end
        chk("wait255_stalls", 16'(cnt), 16'd255);
        step();

        // start is ignored while running
        bus1.opcode = OP_NOP; bus1.start = 1'b1;
        settle();
        chk("run_start_cw", 16'(cw1()), 16'(w_run_nop));
        step();
        bus1.start = 1'b0;
        settle();
        chk("run_start_after", 16'(cw1()), 16'(w_run_nop));
        step();

        // HALT, hold for 10 cycles, resume on start
        bus1.opcode = OP_HALT;
        settle();
        chk("halt_issue", 16'(cw1()), 16'(w_wait));
        step();
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("halt_hold", 16'(cw1()), 16'(cw(0, 1, 0, 0, 0, 3'b000, 1, 0)));
            step();
        end
        bus1.start = 1'b1;
        settle();
        chk("halt_resume", 16'(cw1()), 16'(cw(1, 1, 0, 0, 0, 3'b000, 1, 0)));
        step();
        bus1.start = 1'b0;
        bus1.opcode = OP_NOP;
        settle();
        chk("halt_after", 16'(cw1()), 16'(w_run_nop));
        step();

        // Illegal opcode: NOP behaviour, sticky err from the next cycle
        bus1.opcode = 6'b101111;
        settle();
        chk("illegal_cw", 16'(cw1()), 16'(w_run_nop));
        step();
        bus1.opcode = OP_NOP;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("err_sticky", 16'(cw1()), 16'(cw(1, 1, 0, 0, 0, 3'b000, 0, 1)));
            step();
        end

        // Reset in the middle of a long WAIT
        bus1.opcode = OP_WAIT; bus1.imm = 10'd200;
        step();
        step();
        settle();
        chk("wait200_mid", 16'(cw1()), 16'(cw(0, 1, 0, 0, 0, 3'b000, 0, 1)));
        reset = 1'b1;
        settle();
        chk("wait200_rst_cw", 16'(cw1()), 16'(cw(0, 1, 0, 0, 0, 3'b000, 0, 1)));
        step();
        reset = 1'b0;
        settle();
        chk("wait200_rst_state", 16'(dut.state_reg), 16'(ST_IDLE));
        chk("wait200_rst_cnt", 16'(dut.cnt_reg), 16'd0);
        chk("wait200_rst_cw", 16'(cw1()), 16'(w_idle));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uc_seq.md
Name: uc_seq

Overview:
- Sequencing control unit for the single-cycle CPU datapath `cd`.
- Decodes the 6-bit opcode and the zero flag into the datapath controls: s_inc, s_inm, we3, wez, op_alu.
- Adds a PC-enable so the CPU can sit idle after reset, execute timed WAIT instructions and HALT/resume on a start pulse.
- `cd` gains a pc_en input gating its PC register; no other datapath change.

Parameters:
- WAIT_W, 8: width of the WAIT down-counter; immediate taken from imm[WAIT_W-1:0].
- AUTO_START, 0: 1 means the block leaves reset directly in RUN instead of IDLE.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instruction bits [15:10] from `cd`
- imm  in  10  instruction bits [9:0] from `cd` (WAIT count)
- z  in  1  registered zero flag from `cd`
- start  in  1  single-cycle pulse: leave IDLE or resume from HALT
- s_inc  out  1  1 = PC+1, 0 = jump target
- s_inm  out  1  1 = write immediate, 0 = write ALU result
- we3  out  1  register file write enable
- wez  out  1  zero-flag write enable
- op_alu  out  3  ALU operation
- pc_en  out  1  PC register load enable
- halted  out  1  high in HALT state
- err  out  1  sticky illegal-opcode flag

Behaviour:
- Reset is synchronous and active-high: reset=1 at a clk edge forces the state to IDLE (RUN if AUTO_START=1), clears the counter and clears err.
- States: IDLE, RUN, WAIT, HALT; 2-bit encoding.
- Output defaults (IDLE, WAIT, HALT, and during reset): we3=0, wez=0, s_inm=0, s_inc=1, op_alu=000, pc_en=0.
- All outputs are combinational from state, opcode and z. Zero added latency, so one instruction completes per cycle in RUN.
- IDLE: start=1 moves to RUN next cycle; PC stays at 0.
- RUN decode, all with pc_en=1 unless stated:
  - 0ooo xx = ALU op: op_alu=ooo, we3=1, wez=1, s_inc=1.
  - 1000xx = LOADI: s_inm=1, we3=1, s_inc=1.
  - 100100 = JMP: s_inc=0.
  - 100101 = JZ: s_inc=~z.
  - 100110 = JNZ: s_inc=z.
  - 100111 = NOP: s_inc=1.
  - 101000 = WAIT:
    - n = imm[WAIT_W-1:0].
    - n=0: behaves as NOP.
    - n>0: pc_en=0, load cnt=n, go to WAIT.
  - 111111 = HALT: pc_en=0, go to HALT.
  - Any other opcode: treated as NOP; err set to 1 on the next edge and held until reset.
- WAIT:
  - cnt decrements each cycle.
  - In the cycle cnt==1: pc_en=1, s_inc=1, next state RUN.
  - Total cycles spent on a WAIT instruction = n+1.
  - Max n = 2^WAIT_W-1, no wrap.
- HALT:
  - halted=1, PC holds on the HALT address.
  - start=1: that same cycle pc_en=1, s_inc=1; next state RUN at HALT+1.
- start is ignored in RUN and WAIT.
- z is sampled combinationally in the jump cycle. A flag written by the instruction immediately before the jump is visible, because the ffd updates at the edge between the two instructions.
- reset=1 mid-WAIT or mid-HALT aborts immediately; the counter is cleared.

Decomposition:
- Shared package `uc_pkg`:
  - opcode constants: OP_LOADI, OP_JMP, OP_JZ, OP_JNZ, OP_NOP, OP_WAIT, OP_HALT;
  - ALU-class mask;
  - state typedef and state constants.
- One natural sub-module, `uc_decode`: purely combinational opcode+z to control-word decode (s_inc, s_inm, we3, wez, op_alu, is_wait, is_halt, illegal).
- uc_seq holds the FSM, the WAIT counter, the err register and the output gating.

Test Plan:
- Reset held 2 cycles, then released, no start: pc_en=0, we3=0, state IDLE for 5 cycles. With AUTO_START=1: RUN on the first cycle after reset.
- start pulse, then opcode=000100 (op_alu 001): we3=1, wez=1, op_alu=001, s_inc=1, pc_en=1 in the same cycle.
- JZ with z=1: s_inc=0. JZ with z=0: s_inc=1. JNZ with z=0: s_inc=0. LOADI: s_inm=1, we3=1, wez=0.
- WAIT with imm=3: pc_en=0 for 3 cycles, then pc_en=1 on the 4th. WAIT with imm=0: pc_en=1 immediately, stays RUN.
- HALT: halted=1, pc_en=0 for 10 cycles. start pulse: pc_en=1, s_inc=1 in that cycle, halted=0 next cycle. start asserted in RUN: no effect.
- Opcode 101111: treated as NOP (pc_en=1, we3=0), err=1 from the next cycle and held. reset=1 during WAIT with imm=200: IDLE and err=0 after the edge.
